// File: rtl/serial_add_sub_pkg.sv
// ============================================================================
// serial_add_sub_pkg : shared types and sizing helpers for serial_add_sub
// Revision: 1.0
// ============================================================================
`default_nettype none

package serial_add_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // A single-chunk operation still needs a 1-bit counter.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_add_sub_chunk_adder.sv
// ============================================================================
// chunk_adder : CHUNK-bit ripple adder built from full-adder cells
// Revision: 1.0
// ============================================================================
`default_nettype none

module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[CHUNK];
  assign cmsb = c[CHUNK-1];

endmodule

`default_nettype wire

// File: rtl/serial_add_sub.sv
// ============================================================================
// serial_add_sub : digit-serial two's-complement adder/subtractor, LSB first
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_add_sub
  import serial_add_sub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int CW     = cnt_width(NCHUNK);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  logic [CHUNK-1:0] chunk_sum;
  logic             chunk_cout, chunk_cmsb;
  logic [WIDTH-1:0] a_shift, b_shift, sum_shift;

  chunk_adder #(.CHUNK(CHUNK)) u_chunk_adder (
    .a    (a_q[CHUNK-1:0]),
    .b    (b_q[CHUNK-1:0]),
    .cin  (carry_q),
    .sum  (chunk_sum),
    .cout (chunk_cout),
    .cmsb (chunk_cmsb)
  );

  // Result fills from the MSB side so after NCHUNK shifts chunk 0 sits at the bottom.
  if (CHUNK == WIDTH) begin : g_single
    assign a_shift   = '0;
    assign b_shift   = '0;
    assign sum_shift = chunk_sum;
  end else begin : g_multi
    assign a_shift   = {{CHUNK{1'b0}}, a_q[WIDTH-1:CHUNK]};
    assign b_shift   = {{CHUNK{1'b0}}, b_q[WIDTH-1:CHUNK]};
    assign sum_shift = {chunk_sum, sum_q[WIDTH-1:CHUNK]};
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b ^ {WIDTH{mode}};
          carry_d = mode;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_shift;
        b_d     = b_shift;
        sum_d   = sum_shift;
        carry_d = chunk_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(NCHUNK - 1)) begin
          carry_out_d = chunk_cout;
          overflow_d  = chunk_cmsb ^ chunk_cout;
          zero_d      = (sum_shift == '0);
          state_d     = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
    end
  end

  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_add_sub.sv
// ============================================================================
// tb_serial_add_sub : directed-vector bench for serial_add_sub (16/4 and 8/8)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_serial_add_sub;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0, mode = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        busy, done, carry_out, overflow, zero;
  logic [15:0] sum;

  logic        start8 = 1'b0, mode8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, carry_out8, overflow8, zero8;
  logic [7:0]  sum8;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_add_sub #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .mode(mode),
    .busy(busy), .done(done), .sum(sum), .carry_out(carry_out),
    .overflow(overflow), .zero(zero)
  );

  serial_add_sub #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .mode(mode8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(carry_out8),
    .overflow(overflow8), .zero(zero8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one operation on the 16-bit instance and wait (bounded) for done.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tm,
                       output int cyc, output int busy_cnt);
    a = ta; b = tb_v; mode = tm; start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 0; busy_cnt = 0;
    while (!done && cyc < 20) begin
      if (busy) busy_cnt++;
      tick();
      cyc++;
    end
  endtask

  task automatic check_result(input string name, input logic [15:0] exp_sum,
                              input logic exp_c, input logic exp_v, input logic exp_z);
    tests++;
    if (done !== 1'b1) begin
      fails++; $display("FAIL %s done: got %b want 1", name, done);
    end
    tests++;
    if ({sum, carry_out, overflow, zero} !== {exp_sum, exp_c, exp_v, exp_z}) begin
      fails++;
      $display("FAIL %s result: got sum=%h c=%b v=%b z=%b want sum=%h c=%b v=%b z=%b",
               name, sum, carry_out, overflow, zero, exp_sum, exp_c, exp_v, exp_z);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    tests++;
    if ({busy, done, sum, carry_out, overflow, zero} !== 21'd0) begin
      fails++; $display("FAIL reset16: got busy=%b done=%b sum=%h c=%b v=%b z=%b want all 0",
                        busy, done, sum, carry_out, overflow, zero);
    end
    tests++;
    if ({busy8, done8, sum8, carry_out8, overflow8, zero8} !== 13'd0) begin
      fails++; $display("FAIL reset8: got busy=%b done=%b sum=%h want all 0", busy8, done8, sum8);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_add();
    int cyc, bc;
    do_op(16'h1234, 16'h0FF0, 1'b0, cyc, bc);
    tests++;
    if (cyc !== 4 || bc !== 4) begin
      fails++; $display("FAIL add_latency: got cyc=%0d busy=%0d want 4/4", cyc, bc);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL add_busy_in_done: got %b want 0", busy);
    end
    check_result("add", 16'h2224, 1'b0, 1'b0, 1'b0);
    tick();
    tests++;
    if (done !== 1'b0) begin
      fails++; $display("FAIL done_pulse_width: got %b want 0", done);
    end
    tick(); tick();
    tests++;
    if ({sum, carry_out, overflow, zero} !== {16'h2224, 3'b000}) begin
      fails++; $display("FAIL idle_hold: got sum=%h want 2224", sum);
    end
  endtask

  task automatic test_subtract();
    int cyc, bc;
    do_op(16'h0005, 16'h0005, 1'b1, cyc, bc);
    check_result("sub_equal", 16'h0000, 1'b1, 1'b0, 1'b1);
    tick();
    do_op(16'h0000, 16'h0001, 1'b1, cyc, bc);
    check_result("sub_borrow", 16'hFFFF, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_overflow();
    int cyc, bc;
    do_op(16'h7FFF, 16'h0001, 1'b0, cyc, bc);
    check_result("add_ovf", 16'h8000, 1'b0, 1'b1, 1'b0);
    tick();
    do_op(16'h8000, 16'h0001, 1'b1, cyc, bc);
    check_result("sub_ovf", 16'h7FFF, 1'b1, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_back_to_back();
    int cyc;
    a = 16'h1111; b = 16'h2222; mode = 1'b0; start = 1'b1;
    tick();
    // Junk operands with start still high must be ignored during RUN.
    a = 16'hFFFF; b = 16'hFFFF; mode = 1'b1;
    cyc = 0;
    while (!done && cyc < 20) begin tick(); cyc++; end
    check_result("b2b_first", 16'h3333, 1'b0, 1'b0, 1'b0);
    a = 16'h0100; b = 16'h0001; mode = 1'b1;
    tick();
    cyc = 1;
    while (!done && cyc < 20) begin tick(); cyc++; end
    start = 1'b0;
    tests++;
    if (cyc !== 5) begin
      fails++; $display("FAIL b2b_spacing: got %0d cycles want 5", cyc);
    end
    check_result("b2b_second", 16'h00FF, 1'b1, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_reset_abort();
    int cyc, bc, seen;
    a = 16'h4321; b = 16'h1111; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if ({busy, done, sum, carry_out, overflow, zero} !== 21'd0) begin
      fails++; $display("FAIL abort_state: got busy=%b done=%b sum=%h c=%b v=%b z=%b want all 0",
                        busy, done, sum, carry_out, overflow, zero);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) seen = 1;
      tick();
    end
    tests++;
    if (seen !== 0) begin
      fails++; $display("FAIL abort_no_done: got done pulse want none");
    end
    do_op(16'h0003, 16'h0004, 1'b0, cyc, bc);
    check_result("after_abort", 16'h0007, 1'b0, 1'b0, 1'b0);
    tick();
  endtask

  task automatic test_single_chunk();
    int cyc;
    a8 = 8'hFF; b8 = 8'h01; mode8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tests++;
    if (busy8 !== 1'b1) begin
      fails++; $display("FAIL w8_busy: got %b want 1", busy8);
    end
    cyc = 0;
    while (!done8 && cyc < 10) begin tick(); cyc++; end
    tests++;
    if (cyc !== 1) begin
      fails++; $display("FAIL w8_latency: got %0d want 1", cyc);
    end
    tests++;
    if ({done8, sum8, carry_out8, overflow8, zero8} !== {1'b1, 8'h00, 1'b1, 1'b0, 1'b1}) begin
      fails++; $display("FAIL w8_result: got done=%b sum=%h c=%b v=%b z=%b want 1 00 1 0 1",
                        done8, sum8, carry_out8, overflow8, zero8);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_subtract();
    test_overflow();
    test_back_to_back();
    test_reset_abort();
    test_single_chunk();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
